pll_reset_gen: RTL and testbench
================================

PLL_RESET_GEN -- requirements
Module: pll_reset_gen

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 1024; it is the number of consecutive clocks that synchronized lock must stay high before reset release; legal range is 2..65536.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2; it is the number of synchronizer flops on locked; legal range is 2..4.
REQ-003 The block SHALL have parameter LOSS_WIDTH, default 8; it is the width of the lock-loss event counter.
REQ-004 The block SHALL have port clock, input, 1 bit: the PLL output clock (clock_out of the PLL wrapper), rising-edge only.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset; this is the only clock and the only reset.
REQ-006 The block SHALL have port locked, input, 1 bit: the PLL lock indication, asynchronous to clock.
REQ-007 The block SHALL have port clear_status, input, 1 bit: a synchronous single-cycle pulse that clears the loss status.
REQ-008 The block SHALL have port sys_reset_n, output, 1 bit: active-low reset for downstream logic in the clock domain.
REQ-009 The block SHALL have port ready, output, 1 bit: high while the block is in state RUN.
REQ-010 The block SHALL have port lock_lost, output, 1 bit: sticky flag, set on loss of lock while in RUN.
REQ-011 The block SHALL have port loss_count, output, LOSS_WIDTH bits: saturating count of lock-loss events.

Function
REQ-012 The block SHALL pass locked through a SYNC_STAGES-deep flop chain; locked_sync is the last flop; no other logic SHALL sample locked directly.
REQ-013 The block SHALL implement states WAIT_LOCK, STABILIZE and RUN, encoded in registers.
REQ-014 In WAIT_LOCK, when locked_sync=1, the block SHALL go to STABILIZE at the next edge with the stability counter cleared to 0.
REQ-015 In STABILIZE, the counter SHALL increment by 1 each edge while locked_sync=1.
REQ-016 In STABILIZE, the block SHALL go to RUN at the edge where counter==STABLE_CYCLES-1 and locked_sync=1.
REQ-017 In STABILIZE, locked_sync=0 SHALL return the block to WAIT_LOCK at the next edge; loss_count and lock_lost SHALL NOT change.
REQ-018 In RUN, locked_sync=0 SHALL take the block to WAIT_LOCK at the next edge, increment loss_count (saturating at 2^LOSS_WIDTH-1) and set lock_lost.
REQ-019 sys_reset_n and ready SHALL be registered, and SHALL be 1 exactly while the state register equals RUN; both change on the same edge as the state transition.
REQ-020 Release latency: with locked stable high, sys_reset_n SHALL rise exactly SYNC_STAGES+STABLE_CYCLES edges after the first edge at which the first synchronizer flop captures 1.
REQ-021 Assert latency: sys_reset_n SHALL fall exactly SYNC_STAGES edges after the first edge at which the first synchronizer flop captures 0 while in RUN.
REQ-022 The stability counter SHALL be wide enough for STABLE_CYCLES-1, SHALL never wrap, and SHALL hold 0 outside STABILIZE.
REQ-023 clear_status=1 SHALL zero loss_count and lock_lost at the next edge.
REQ-024 If clear_status coincides with a loss event, the loss event SHALL win: loss_count=1 and lock_lost=1.
REQ-025 At saturation, a further loss event SHALL keep loss_count at its maximum and SHALL still set lock_lost.
REQ-026 A locked glitch shorter than the synchronizer depth that never reaches locked_sync SHALL have no effect.

Reset
REQ-027 reset_n=0 SHALL immediately, without waiting for clock, force: synchronizer flops to 0, state to WAIT_LOCK, counter to 0, sys_reset_n=0, ready=0, lock_lost=0, loss_count=0.
REQ-028 Assertion of reset_n mid-STABILIZE or mid-RUN SHALL abort the block to the reset values; after release, a full STABILIZE period SHALL be required again.
REQ-029 sys_reset_n SHALL be driven from a flop whose async clear is reset_n, so that downstream reset assertion is asynchronous and its release is synchronous to clock.

Verification (STABLE_CYCLES=16, SYNC_STAGES=2, LOSS_WIDTH=8)
REQ-030 Basic release: release reset_n, then raise locked -> sys_reset_n=1 and ready=1 exactly 18 edges after the first capturing edge; loss_count=0.
REQ-031 Unstable lock: drop locked for 3 cycles after 10 stable cycles, then raise it again -> no release before a fresh 18-edge window completes; loss_count=0; lock_lost=0.
REQ-032 Loss in RUN: drop locked while in RUN -> sys_reset_n=0 after 2 edges, loss_count=1, lock_lost=1; relock -> release after 18 edges, lock_lost stays 1.
REQ-033 Clear collision: pulse clear_status on the same edge as a RUN loss event, with loss_count=5 beforehand -> loss_count=1, lock_lost=1; a later lone clear -> 0/0.
REQ-034 Saturation: force 256 loss events -> loss_count=255 and holds at 255.
REQ-035 Async reset: assert reset_n mid-RUN between clock edges -> sys_reset_n and ready drop to 0 with no clock edge; all outputs take their reset values.

Source files
------------

// File: rtl/pll_reset_gen.sv
// PLL reset generator: synchronizes the PLL lock flag, holds downstream reset until
// lock has been stable for STABLE_CYCLES clocks, and records lock-loss events.
module pll_reset_gen #(
  parameter int STABLE_CYCLES = 1024,
  parameter int SYNC_STAGES   = 2,
  parameter int LOSS_WIDTH    = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  locked,
  input  logic                  clear_status,
  output logic                  sys_reset_n,
  output logic                  ready,
  output logic                  lock_lost,
  output logic [LOSS_WIDTH-1:0] loss_count,
  output logic [1:0]            state_dbg
);

  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [LOSS_WIDTH-1:0] LOSS_MAX = {LOSS_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    locked_sync;
  logic                    loss_event;
  logic                    lock_lost_d;
  logic [LOSS_WIDTH-1:0]   loss_count_d;

  // locked is asynchronous to clock; only the last synchronizer flop is used.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
  end

  assign locked_sync = sync_q[SYNC_STAGES-1];
  assign loss_event  = (state_q == RUN) && !locked_sync;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      WAIT_LOCK: if (locked_sync) state_d = STABILIZE;
      STABILIZE: begin
        if (!locked_sync)            state_d = WAIT_LOCK;
        else if (cnt_q == CNT_LAST)  state_d = RUN;
        else                         cnt_d   = cnt_q + 1'b1;
      end
      RUN:       if (!locked_sync) state_d = WAIT_LOCK;
      default:   state_d = WAIT_LOCK;
    endcase
  end

  // A loss event takes precedence over a coincident clear.
  always_comb begin
    lock_lost_d  = lock_lost;
    loss_count_d = loss_count;
    if (loss_event) begin
      lock_lost_d  = 1'b1;
      if (clear_status)             loss_count_d = LOSS_WIDTH'(1);
      else if (loss_count != LOSS_MAX) loss_count_d = loss_count + 1'b1;
    end else if (clear_status) begin
      lock_lost_d  = 1'b0;
      loss_count_d = '0;
    end
  end

  // sys_reset_n/ready are registered from next-state so they move with the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      sys_reset_n <= 1'b0;
      ready       <= 1'b0;
      lock_lost   <= 1'b0;
      loss_count  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sys_reset_n <= (state_d == RUN);
      ready       <= (state_d == RUN);
      lock_lost   <= lock_lost_d;
      loss_count  <= loss_count_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_pll_reset_gen.sv
// Directed bench for pll_reset_gen with STABLE_CYCLES=16, SYNC_STAGES=2, LOSS_WIDTH=8.
module tb_pll_reset_gen;

  localparam int STABLE = 16;
  localparam int SYNC   = 2;
  localparam int LW     = 8;
  localparam int REL    = SYNC + STABLE;  // edges from first capture to release
  localparam logic [1:0] S_WAIT = 2'd0, S_STAB = 2'd1, S_RUN = 2'd2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          locked;
  logic          clear_status;
  logic          sys_reset_n;
  logic          ready;
  logic          lock_lost;
  logic [LW-1:0] loss_count;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  pll_reset_gen #(.STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC), .LOSS_WIDTH(LW)) dut (
    .clock(clock), .reset_n(reset_n), .locked(locked), .clear_status(clear_status),
    .sys_reset_n(sys_reset_n), .ready(ready), .lock_lost(lock_lost),
    .loss_count(loss_count), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  // ---- driver tasks ----
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; locked = 1'b0; clear_status = 1'b0;
    tick(3);
    @(negedge clock);
    reset_n = 1'b1;
    tick(1);
  endtask

  // Raise locked and wait for release (first capture edge is the next posedge).
  task automatic go_run();
    locked = 1'b1;
    tick(REL + 1);
  endtask

  // One complete loss event from RUN followed by relock back into RUN.
  task automatic lose_and_relock();
    locked = 1'b0;
    tick(SYNC + 2);
    go_run();
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    reset_n = 1'b0; locked = 1'b0; clear_status = 1'b0;
    #2;
    checks++;
    if ({sys_reset_n, ready, lock_lost} !== 3'b000 || loss_count !== 8'd0 || state_dbg !== S_WAIT) begin
      errors++;
      $display("FAIL reset_values: sys=%b rdy=%b lost=%b cnt=%0d st=%0d, want 0 0 0 0 0",
               sys_reset_n, ready, lock_lost, loss_count, state_dbg);
    end
    do_reset();
  endtask

  task automatic test_basic_release();
    do_reset();
    locked = 1'b1;
    tick(REL);
    checks++;
    if (sys_reset_n !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL release_early: sys=%b rdy=%b after %0d edges, want 0 0", sys_reset_n, ready, REL);
    end
    tick(1);
    checks++;
    if (sys_reset_n !== 1'b1 || ready !== 1'b1 || state_dbg !== S_RUN || loss_count !== 8'd0) begin
      errors++;
      $display("FAIL release_edge: sys=%b rdy=%b st=%0d cnt=%0d, want 1 1 2 0",
               sys_reset_n, ready, state_dbg, loss_count);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    tick(1);
    #2 locked = 1'b1;
    #2 locked = 1'b0;
    tick(5);
    checks++;
    if (state_dbg !== S_WAIT || sys_reset_n !== 1'b0) begin
      errors++;
      $display("FAIL glitch_ignored: st=%0d sys=%b, want 0 0", state_dbg, sys_reset_n);
    end
  endtask

  task automatic test_unstable_lock();
    do_reset();
    locked = 1'b1;
    tick(10);
    checks++;
    if (state_dbg !== S_STAB) begin
      errors++;
      $display("FAIL unstable_in_stab: st=%0d, want 1", state_dbg);
    end
    locked = 1'b0;
    tick(3);
    checks++;
    if (state_dbg !== S_WAIT) begin
      errors++;
      $display("FAIL unstable_back_wait: st=%0d, want 0", state_dbg);
    end
    locked = 1'b1;
    tick(REL);
    checks++;
    if (sys_reset_n !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL unstable_early: sys=%b rdy=%b, want 0 0", sys_reset_n, ready);
    end
    tick(1);
    checks++;
    if (sys_reset_n !== 1'b1 || loss_count !== 8'd0 || lock_lost !== 1'b0) begin
      errors++;
      $display("FAIL unstable_release: sys=%b cnt=%0d lost=%b, want 1 0 0",
               sys_reset_n, loss_count, lock_lost);
    end
  endtask

  task automatic test_loss_in_run();
    do_reset();
    go_run();
    locked = 1'b0;
    tick(SYNC);
    checks++;
    if (sys_reset_n !== 1'b1) begin
      errors++;
      $display("FAIL loss_early: sys=%b after %0d edges, want 1", sys_reset_n, SYNC);
    end
    tick(1);
    checks++;
    if (sys_reset_n !== 1'b0 || ready !== 1'b0 || loss_count !== 8'd1 || lock_lost !== 1'b1) begin
      errors++;
      $display("FAIL loss_assert: sys=%b rdy=%b cnt=%0d lost=%b, want 0 0 1 1",
               sys_reset_n, ready, loss_count, lock_lost);
    end
    locked = 1'b1;
    tick(REL);
    checks++;
    if (sys_reset_n !== 1'b0) begin
      errors++;
      $display("FAIL relock_early: sys=%b, want 0", sys_reset_n);
    end
    tick(1);
    checks++;
    if (sys_reset_n !== 1'b1 || lock_lost !== 1'b1 || loss_count !== 8'd1) begin
      errors++;
      $display("FAIL relock_release: sys=%b lost=%b cnt=%0d, want 1 1 1",
               sys_reset_n, lock_lost, loss_count);
    end
  endtask

  task automatic test_clear_collision();
    do_reset();
    go_run();
    for (int i = 0; i < 5; i++) lose_and_relock();
    checks++;
    if (loss_count !== 8'd5 || state_dbg !== S_RUN) begin
      errors++;
      $display("FAIL pre_collision: cnt=%0d st=%0d, want 5 2", loss_count, state_dbg);
    end
    locked = 1'b0;
    tick(SYNC);
    clear_status = 1'b1;  // lands on the loss edge
    tick(1);
    clear_status = 1'b0;
    checks++;
    if (loss_count !== 8'd1 || lock_lost !== 1'b1) begin
      errors++;
      $display("FAIL clear_collision: cnt=%0d lost=%b, want 1 1", loss_count, lock_lost);
    end
    tick(2);
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    checks++;
    if (loss_count !== 8'd0 || lock_lost !== 1'b0) begin
      errors++;
      $display("FAIL lone_clear: cnt=%0d lost=%b, want 0 0", loss_count, lock_lost);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    go_run();
    for (int i = 0; i < 255; i++) lose_and_relock();
    checks++;
    if (loss_count !== 8'd255) begin
      errors++;
      $display("FAIL sat_reach: cnt=%0d, want 255", loss_count);
    end
    lose_and_relock();
    checks++;
    if (loss_count !== 8'd255 || lock_lost !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold: cnt=%0d lost=%b, want 255 1", loss_count, lock_lost);
    end
    lose_and_relock();
    checks++;
    if (loss_count !== 8'd255) begin
      errors++;
      $display("FAIL sat_hold2: cnt=%0d, want 255", loss_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    go_run();
    lose_and_relock();
    #3 reset_n = 1'b0;  // between edges
    #1;
    checks++;
    if ({sys_reset_n, ready, lock_lost} !== 3'b000 || loss_count !== 8'd0 || state_dbg !== S_WAIT) begin
      errors++;
      $display("FAIL async_reset: sys=%b rdy=%b lost=%b cnt=%0d st=%0d, want 0 0 0 0 0",
               sys_reset_n, ready, lock_lost, loss_count, state_dbg);
    end
    tick(2);
    @(negedge clock);
    reset_n = 1'b1;  // locked stays high: a full window is still required
    tick(REL);
    checks++;
    if (sys_reset_n !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_early: sys=%b, want 0", sys_reset_n);
    end
    tick(1);
    checks++;
    if (sys_reset_n !== 1'b1 || ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_release: sys=%b rdy=%b, want 1 1", sys_reset_n, ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic_release();
    test_glitch();
    test_unstable_lock();
    test_loss_in_run();
    test_clear_collision();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
